dot_accumulator: RTL and testbench

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

---
 rtl/dot_accumulator.sv | 59 +++++
 tb/tb_dot_accumulator.sv | 118 +++++++++++
 2 files changed

// File: rtl/dot_accumulator.sv
// dot_accumulator: accumulates VECTOR_LEN signed samples, rounds/shifts the sum and flags range overflow; DOT_ACCUMULATOR_SATURATION_EN clamps RES on overflow instead of wrapping
module dot_accumulator #(
  parameter int IN_WIDTH   = 21,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int VECTOR_LEN = 8,
  parameter int SHIFT      = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        inReady,
  input  logic signed [IN_WIDTH-1:0]  X,
  output logic                        outReady,
  output logic signed [OUT_WIDTH-1:0] RES,
  output logic                        ovf,
  output logic                        busy
);
  localparam int CW = $clog2(VECTOR_LEN);
  localparam int RS = SHIFT == 0 ? 0 : SHIFT - 1;
  localparam logic signed [ACC_WIDTH:0] RND = SHIFT == 0 ? {(ACC_WIDTH+1){1'b0}} : (ACC_WIDTH+1)'(1) << RS;
  logic [CW-1:0] cnt, cnt_n;
  logic signed [ACC_WIDTH-1:0] acc, acc_n, xe, sum;
  logic signed [ACC_WIDTH:0] r;
  logic signed [OUT_WIDTH-1:0] res_c;
  logic done, ovf_c;
  always_comb begin
    xe = ACC_WIDTH'(X);
    sum = acc + xe;
    r = ($signed({sum[ACC_WIDTH-1], sum}) + RND) >>> SHIFT;
    done = inReady && !clear && cnt == CW'(VECTOR_LEN - 1);
    ovf_c = !(&r[ACC_WIDTH:OUT_WIDTH-1] || !(|r[ACC_WIDTH:OUT_WIDTH-1]));
`ifdef DOT_ACCUMULATOR_SATURATION_EN
    res_c = ovf_c ? (r[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}}) : r[OUT_WIDTH-1:0];
`else
    res_c = r[OUT_WIDTH-1:0];
`endif
    acc_n = clear ? (inReady ? xe : '0) : inReady ? (done ? '0 : sum) : acc;
    cnt_n = clear ? (inReady ? CW'(1) : '0) : inReady ? (done ? '0 : cnt + 1'b1) : cnt;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      outReady <= 1'b0;
      RES <= '0;
      ovf <= 1'b0;
    end else if (enable) begin
      acc <= acc_n;
      cnt <= cnt_n;
      outReady <= done;
      if (done) begin
        RES <= res_c;
        ovf <= ovf_c;
      end
    end
  assign busy = cnt != '0;
endmodule

// File: tb/tb_dot_accumulator.sv
// tb_dot_accumulator: scoreboard bench for dot_accumulator with VECTOR_LEN=4, SHIFT=2, OUT_WIDTH=8
module tb_dot_accumulator;
  localparam int IW = 21, AW = 32, OW = 8, VL = 4, SH = 2;
`ifdef DOT_ACCUMULATOR_SATURATION_EN
  localparam int RANGE_RES = 127;
`else
  localparam int RANGE_RES = -56;
`endif
  typedef struct {int res; logic ov; int at;} exp_t;
  logic clk = 0, reset = 0, enable = 0, clear = 0, inReady = 0;
  logic signed [IW-1:0] X = '0;
  logic outReady, ovf, busy;
  logic signed [OW-1:0] RES;
  int cyc = 0, checks = 0, passes = 0;
  exp_t q[$];
  exp_t e;
  dot_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .VECTOR_LEN(VL), .SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inReady(inReady), .X(X),
    .outReady(outReady), .RES(RES), .ovf(ovf), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  always @(negedge clk)
    if (!reset && outReady) begin
      if (q.size() == 0) chk("unexpected outReady", 1, 0);
      else begin
        e = q.pop_front();
        chk("RES", RES, e.res);
        chk("ovf", ovf, e.ov);
        chk("latency cycle", cyc, e.at);
      end
    end
  task automatic drive(logic en, logic clr, logic ir, int x);
    @(negedge clk);
    enable = en;
    clear = clr;
    inReady = ir;
    X = IW'(x);
  endtask
  task automatic push(int res, logic ov);
    q.push_back('{res: res, ov: ov, at: cyc + 1});
  endtask
  task automatic vec(int a, int b, int c, int d, int res, logic ov);
    drive(1, 0, 1, a);
    drive(1, 0, 1, b);
    drive(1, 0, 1, c);
    drive(1, 0, 1, d);
    push(res, ov);
    drive(1, 0, 0, 0);
  endtask
  initial begin
    #2 reset = 1;
    #1;
    chk("reset RES", RES, 0);
    chk("reset ovf", ovf, 0);
    chk("reset outReady", outReady, 0);
    chk("reset busy", busy, 0);
    @(negedge clk) reset = 0;
    vec(1, 2, 3, 4, 3, 0);
    chk("busy idle after basic", busy, 0);
    vec(-3, -3, -3, -2, -3, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, i < 4 ? 4 : 8);
      if (i > 0) chk("b2b busy", busy, (i % 4) != 0);
      if (i == 3) push(4, 0);
      if (i == 7) push(8, 0);
    end
    drive(1, 0, 0, 0);
    chk("b2b busy end", busy, 0);
    vec(200, 200, 200, 200, RANGE_RES, 1);
    drive(1, 0, 1, 5);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 99);
    chk("busy held while disabled", busy, 1);
    drive(1, 0, 1, 5);
    drive(1, 0, 1, 5);
    drive(1, 0, 1, 5);
    push(5, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 7);
    drive(1, 0, 1, 7);
    drive(1, 0, 0, 0);
    chk("busy before reset", busy, 1);
    #2 reset = 1;
    #1 chk("busy async reset", busy, 0);
    @(negedge clk) reset = 0;
    vec(1, 2, 3, 4, 3, 0);
    drive(1, 0, 1, 9);
    drive(1, 0, 1, 9);
    drive(1, 1, 1, 1);
    drive(1, 0, 1, 2);
    chk("busy after clear+sample", busy, 1);
    drive(1, 0, 1, 3);
    drive(1, 0, 1, 4);
    push(3, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 7);
    drive(1, 0, 1, 7);
    drive(1, 0, 1, 7);
    drive(1, 1, 1, 1);
    drive(1, 0, 1, 2);
    drive(1, 0, 1, 3);
    drive(1, 0, 1, 4);
    push(3, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    chk("busy after plain clear", busy, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("results drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
